// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter: ALU and load/store results each land in a private skid
// FIFO; a round-robin arbiter drains both into one registered ROB completion
// port that honours ROB backpressure.
module fu_wb_arbiter #(
  parameter int GPR_SIZE     = 64,
  parameter int ROB_IDX_SIZE = 4,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_alu_done,
  input  logic [ROB_IDX_SIZE-1:0] in_alu_dst_rob_index,
  input  logic [GPR_SIZE-1:0]     in_alu_value,
  input  logic                    in_alu_set_nzcv,
  input  logic [3:0]              in_alu_nzcv,
  output logic                    out_alu_ready,
  input  logic                    in_ls_done,
  input  logic [ROB_IDX_SIZE-1:0] in_ls_dst_rob_index,
  input  logic [GPR_SIZE-1:0]     in_ls_value,
  output logic                    out_ls_ready,
  input  logic                    in_rob_ready,
  output logic                    out_rob_done,
  output logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
  output logic [GPR_SIZE-1:0]     out_rob_value,
  output logic                    out_rob_set_nzcv,
  output logic [3:0]              out_rob_nzcv,
  output logic                    out_rob_src_ls
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LS = 1'b1} src_e;

  typedef struct packed {
    logic [ROB_IDX_SIZE-1:0] idx;
    logic [GPR_SIZE-1:0]     value;
    logic                    set_nzcv;
    logic [3:0]              nzcv;
  } alu_entry_t;

  typedef struct packed {
    logic [ROB_IDX_SIZE-1:0] idx;
    logic [GPR_SIZE-1:0]     value;
  } ls_entry_t;

  alu_entry_t alu_mem [FIFO_DEPTH];
  ls_entry_t  ls_mem  [FIFO_DEPTH];

  logic [PTR_W-1:0] alu_head, alu_tail, ls_head, ls_tail;
  logic [CNT_W-1:0] alu_count, ls_count;
  src_e             last_grant;

  logic alu_push, ls_push;
  logic load_en, grant_alu, grant_ls;

  // Ready depends only on the registered count, never on a same-cycle pop.
  always_comb begin
    out_alu_ready = (alu_count < CNT_W'(FIFO_DEPTH));
    out_ls_ready  = (ls_count  < CNT_W'(FIFO_DEPTH));
    alu_push      = in_alu_done && out_alu_ready;
    ls_push       = in_ls_done  && out_ls_ready;
  end

  // Round-robin pick: on a tie the source that did not win last time goes.
  always_comb begin
    load_en   = !out_rob_done || in_rob_ready;
    grant_alu = load_en && (alu_count != '0) &&
                ((ls_count == '0) || (last_grant == SRC_LS));
    grant_ls  = load_en && (ls_count != '0) &&
                ((alu_count == '0) || (last_grant == SRC_ALU));
  end

  // FIFO storage; contents need no reset because the counts gate every read.
  always_ff @(posedge in_clk) begin
    if (alu_push)
      alu_mem[alu_tail] <= '{idx: in_alu_dst_rob_index, value: in_alu_value,
                             set_nzcv: in_alu_set_nzcv, nzcv: in_alu_nzcv};
    if (ls_push)
      ls_mem[ls_tail] <= '{idx: in_ls_dst_rob_index, value: in_ls_value};
  end

  // FIFO pointers and occupancy; push and pop in one cycle leave count unchanged.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      alu_head  <= '0;
      alu_tail  <= '0;
      alu_count <= '0;
      ls_head   <= '0;
      ls_tail   <= '0;
      ls_count  <= '0;
    end else begin
      if (alu_push)  alu_tail <= alu_tail + 1'b1;
      if (grant_alu) alu_head <= alu_head + 1'b1;
      case ({alu_push, grant_alu})
        2'b10:   alu_count <= alu_count + 1'b1;
        2'b01:   alu_count <= alu_count - 1'b1;
        default: alu_count <= alu_count;
      endcase
      if (ls_push)  ls_tail <= ls_tail + 1'b1;
      if (grant_ls) ls_head <= ls_head + 1'b1;
      case ({ls_push, grant_ls})
        2'b10:   ls_count <= ls_count + 1'b1;
        2'b01:   ls_count <= ls_count - 1'b1;
        default: ls_count <= ls_count;
      endcase
    end
  end

  // Output register: loads the granted head, or drops done when nothing is pending.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      out_rob_done          <= 1'b0;
      out_rob_dst_rob_index <= '0;
      out_rob_value         <= '0;
      out_rob_set_nzcv      <= 1'b0;
      out_rob_nzcv          <= '0;
      out_rob_src_ls        <= 1'b0;
      last_grant            <= SRC_LS;
    end else if (load_en) begin
      if (grant_alu) begin
        out_rob_done          <= 1'b1;
        out_rob_dst_rob_index <= alu_mem[alu_head].idx;
        out_rob_value         <= alu_mem[alu_head].value;
        out_rob_set_nzcv      <= alu_mem[alu_head].set_nzcv;
        out_rob_nzcv          <= alu_mem[alu_head].nzcv;
        out_rob_src_ls        <= 1'b0;
        last_grant            <= SRC_ALU;
      end else if (grant_ls) begin
        out_rob_done          <= 1'b1;
        out_rob_dst_rob_index <= ls_mem[ls_head].idx;
        out_rob_value         <= ls_mem[ls_head].value;
        out_rob_set_nzcv      <= 1'b0;
        out_rob_nzcv          <= '0;
        out_rob_src_ls        <= 1'b1;
        last_grant            <= SRC_LS;
      end else begin
        out_rob_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Directed bench for fu_wb_arbiter: a cycle-by-cycle vector table plus
// hand-written reset-in-flight and pointer-wrap sequences.
module tb_fu_wb_arbiter;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        in_alu_done;
  logic [3:0]  in_alu_dst_rob_index;
  logic [63:0] in_alu_value;
  logic        in_alu_set_nzcv;
  logic [3:0]  in_alu_nzcv;
  logic        out_alu_ready;
  logic        in_ls_done;
  logic [3:0]  in_ls_dst_rob_index;
  logic [63:0] in_ls_value;
  logic        out_ls_ready;
  logic        in_rob_ready;
  logic        out_rob_done;
  logic [3:0]  out_rob_dst_rob_index;
  logic [63:0] out_rob_value;
  logic        out_rob_set_nzcv;
  logic [3:0]  out_rob_nzcv;
  logic        out_rob_src_ls;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 in_clk = ~in_clk;

  fu_wb_arbiter #(.GPR_SIZE(64), .ROB_IDX_SIZE(4), .FIFO_DEPTH(2)) dut (
    .in_clk               (in_clk),
    .in_rst               (in_rst),
    .in_alu_done          (in_alu_done),
    .in_alu_dst_rob_index (in_alu_dst_rob_index),
    .in_alu_value         (in_alu_value),
    .in_alu_set_nzcv      (in_alu_set_nzcv),
    .in_alu_nzcv          (in_alu_nzcv),
    .out_alu_ready        (out_alu_ready),
    .in_ls_done           (in_ls_done),
    .in_ls_dst_rob_index  (in_ls_dst_rob_index),
    .in_ls_value          (in_ls_value),
    .out_ls_ready         (out_ls_ready),
    .in_rob_ready         (in_rob_ready),
    .out_rob_done         (out_rob_done),
    .out_rob_dst_rob_index(out_rob_dst_rob_index),
    .out_rob_value        (out_rob_value),
    .out_rob_set_nzcv     (out_rob_set_nzcv),
    .out_rob_nzcv         (out_rob_nzcv),
    .out_rob_src_ls       (out_rob_src_ls)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [3:0]  aidx;
    logic [63:0] aval;
    logic        aset;
    logic [3:0]  anzcv;
    logic        lv;
    logic [3:0]  lidx;
    logic [63:0] lval;
    logic        rr;
    logic        e_done;
    logic        chk;
    logic [3:0]  e_idx;
    logic [63:0] e_val;
    logic        e_set;
    logic [3:0]  e_nzcv;
    logic        e_src;
    logic        e_ar;
    logic        e_lr;
  } vec_t;

  function automatic vec_t v(
    input logic rst, input logic av, input logic [3:0] aidx, input logic [63:0] aval,
    input logic aset, input logic [3:0] anzcv, input logic lv, input logic [3:0] lidx,
    input logic [63:0] lval, input logic rr, input logic e_done, input logic chk,
    input logic [3:0] e_idx, input logic [63:0] e_val, input logic e_set,
    input logic [3:0] e_nzcv, input logic e_src, input logic e_ar, input logic e_lr);
    vec_t r;
    r.rst = rst; r.av = av; r.aidx = aidx; r.aval = aval; r.aset = aset;
    r.anzcv = anzcv; r.lv = lv; r.lidx = lidx; r.lval = lval; r.rr = rr;
    r.e_done = e_done; r.chk = chk; r.e_idx = e_idx; r.e_val = e_val;
    r.e_set = e_set; r.e_nzcv = e_nzcv; r.e_src = e_src; r.e_ar = e_ar; r.e_lr = e_lr;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic av, input logic [3:0] aidx,
                       input logic [63:0] aval, input logic aset, input logic [3:0] anzcv,
                       input logic lv, input logic [3:0] lidx, input logic [63:0] lval,
                       input logic rr);
    in_rst = rst; in_alu_done = av; in_alu_dst_rob_index = aidx; in_alu_value = aval;
    in_alu_set_nzcv = aset; in_alu_nzcv = anzcv; in_ls_done = lv;
    in_ls_dst_rob_index = lidx; in_ls_value = lval; in_rob_ready = rr;
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] idx, input logic [63:0] val,
                           input logic set, input logic [3:0] nzcv, input logic src);
    check({tag, " idx"},  64'(out_rob_dst_rob_index), 64'(idx));
    check({tag, " val"},  out_rob_value, val);
    check({tag, " set"},  64'(out_rob_set_nzcv), 64'(set));
    check({tag, " nzcv"}, 64'(out_rob_nzcv), 64'(nzcv));
    check({tag, " src"},  64'(out_rob_src_ls), 64'(src));
  endtask

  vec_t tbl[20];

  initial begin
    // rst av aidx aval aset anzcv lv lidx lval rr | done chk idx val set nzcv src ar lr
    tbl[0]  = v(1, 0, 0, 0,      0, 4'b0000, 0, 0, 0,      1, 0, 1, 0,  0,      0, 4'b0000, 0, 1, 1);
    tbl[1]  = v(0, 1, 3, 'h10,   1, 4'b0100, 0, 0, 0,      1, 0, 0, 0,  0,      0, 4'b0000, 0, 1, 1);
    tbl[2]  = v(0, 0, 0, 0,      0, 4'b0000, 0, 0, 0,      1, 1, 1, 3,  'h10,   1, 4'b0100, 0, 1, 1);
    tbl[3]  = v(0, 0, 0, 0,      0, 4'b0000, 0, 0, 0,      1, 0, 0, 0,  0,      0, 4'b0000, 0, 1, 1);
    tbl[4]  = v(1, 0, 0, 0,      0, 4'b0000, 0, 0, 0,      1, 0, 1, 0,  0,      0, 4'b0000, 0, 1, 1);
    tbl[5]  = v(0, 1, 1, 'h101,  0, 4'b0000, 1, 2, 'h202,  1, 0, 0, 0,  0,      0, 4'b0000, 0, 1, 1);
    tbl[6]  = v(0, 1, 5, 'h105,  1, 4'b1010, 1, 6, 'h206,  1, 1, 1, 1,  'h101,  0, 4'b0000, 0, 1, 0);
    tbl[7]  = v(0, 0, 0, 0,      0, 4'b0000, 0, 0, 0,      1, 1, 1, 2,  'h202,  0, 4'b0000, 1, 1, 1);
    tbl[8]  = v(0, 0, 0, 0,      0, 4'b0000, 0, 0, 0,      1, 1, 1, 5,  'h105,  1, 4'b1010, 0, 1, 1);
    tbl[9]  = v(0, 0, 0, 0,      0, 4'b0000, 0, 0, 0,      1, 1, 1, 6,  'h206,  0, 4'b0000, 1, 1, 1);
    tbl[10] = v(0, 0, 0, 0,      0, 4'b0000, 0, 0, 0,      1, 0, 0, 0,  0,      0, 4'b0000, 0, 1, 1);
    tbl[11] = v(0, 0, 0, 0,      0, 4'b0000, 1, 7, 'h207,  0, 0, 0, 0,  0,      0, 4'b0000, 0, 1, 1);
    tbl[12] = v(0, 0, 0, 0,      0, 4'b0000, 0, 0, 0,      0, 1, 1, 7,  'h207,  0, 4'b0000, 1, 1, 1);
    tbl[13] = v(0, 1, 8, 'h108,  0, 4'b0000, 0, 0, 0,      0, 1, 1, 7,  'h207,  0, 4'b0000, 1, 1, 1);
    tbl[14] = v(0, 1, 9, 'h109,  0, 4'b0000, 0, 0, 0,      0, 1, 1, 7,  'h207,  0, 4'b0000, 1, 0, 1);
    tbl[15] = v(0, 1, 10, 'h10A, 1, 4'b0011, 0, 0, 0,      0, 1, 1, 7,  'h207,  0, 4'b0000, 1, 0, 1);
    tbl[16] = v(0, 1, 10, 'h10A, 1, 4'b0011, 0, 0, 0,      1, 1, 1, 8,  'h108,  0, 4'b0000, 0, 1, 1);
    tbl[17] = v(0, 1, 10, 'h10A, 1, 4'b0011, 0, 0, 0,      1, 1, 1, 9,  'h109,  0, 4'b0000, 0, 1, 1);
    tbl[18] = v(0, 0, 0, 0,      0, 4'b0000, 0, 0, 0,      1, 1, 1, 10, 'h10A,  1, 4'b0011, 0, 1, 1);
    tbl[19] = v(0, 0, 0, 0,      0, 4'b0000, 0, 0, 0,      1, 0, 0, 0,  0,      0, 4'b0000, 0, 1, 1);

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    for (int r = 0; r < 20; r++) begin
      drive(tbl[r].rst, tbl[r].av, tbl[r].aidx, tbl[r].aval, tbl[r].aset, tbl[r].anzcv,
            tbl[r].lv, tbl[r].lidx, tbl[r].lval, tbl[r].rr);
      tick();
      check($sformatf("row%0d done", r), 64'(out_rob_done), 64'(tbl[r].e_done));
      check($sformatf("row%0d alu_ready", r), 64'(out_alu_ready), 64'(tbl[r].e_ar));
      check($sformatf("row%0d ls_ready", r), 64'(out_ls_ready), 64'(tbl[r].e_lr));
      if (tbl[r].chk)
        check_out($sformatf("row%0d", r), tbl[r].e_idx, tbl[r].e_val, tbl[r].e_set,
                  tbl[r].e_nzcv, tbl[r].e_src);
    end

    // Reset while both FIFOs hold entries and the output is valid.
    drive(0, 1, 1, 'h501, 0, 0, 1, 2, 'h502, 0);
    tick();
    check("rstmid fill done", 64'(out_rob_done), 64'd0);
    drive(0, 1, 3, 'h503, 0, 0, 1, 4, 'h504, 0);
    tick();
    check("rstmid pre done", 64'(out_rob_done), 64'd1);
    check_out("rstmid pre", 2, 'h502, 0, 0, 1);
    check("rstmid pre alu_ready", 64'(out_alu_ready), 64'd0);
    drive(1, 1, 3, 'h503, 0, 0, 1, 4, 'h504, 0);
    tick();
    check("rstmid done", 64'(out_rob_done), 64'd0);
    check("rstmid alu_ready", 64'(out_alu_ready), 64'd1);
    check("rstmid ls_ready", 64'(out_ls_ready), 64'd1);
    check_out("rstmid", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    check("rstmid discarded done", 64'(out_rob_done), 64'd0);
    drive(0, 1, 11, 'h50B, 1, 4'b1111, 1, 12, 'h50C, 1);
    tick();
    check("rstmid tie push done", 64'(out_rob_done), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    check("rstmid tie1 done", 64'(out_rob_done), 64'd1);
    check_out("rstmid tie1", 11, 'h50B, 1, 4'b1111, 0);
    tick();
    check("rstmid tie2 done", 64'(out_rob_done), 64'd1);
    check_out("rstmid tie2", 12, 'h50C, 0, 0, 1);

    // Pointer wrap: ten back-to-back ALU results come out in order, one cycle late.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 4'(i), 64'h300 + 64'(i), i[0], 4'(i), 0, 0, 0, 1);
      tick();
      check($sformatf("wrap%0d alu_ready", i), 64'(out_alu_ready), 64'd1);
      if (i == 0) begin
        check("wrap0 done", 64'(out_rob_done), 64'd0);
      end else begin
        check($sformatf("wrap%0d done", i), 64'(out_rob_done), 64'd1);
        check_out($sformatf("wrap%0d", i), 4'(i - 1), 64'h300 + 64'(i - 1),
                  (i - 1) % 2 == 1, 4'(i - 1), 0);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    check("wrap last done", 64'(out_rob_done), 64'd1);
    check_out("wrap last", 9, 'h309, 1, 4'd9, 0);
    tick();
    check("wrap drained done", 64'(out_rob_done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fu_wb_arbiter.md
Name: fu_wb_arbiter

Overview:
Writeback arbiter between the two functional units (ALU and load/store) and the single ROB completion port. Each unit pushes its results into a private 2-deep skid FIFO through a valid/ready handshake. A round-robin arbiter drains the FIFOs into one registered output that can be stalled by ROB backpressure. This resolves the structural hazard when both units complete in the same cycle.

Parameters:
GPR_SIZE, 64, result value width
ROB_IDX_SIZE, 4, ROB index width
FIFO_DEPTH, 2, entries per source FIFO (power of two, >=2)

Ports:
in_clk  input  1  clock, all state updates on posedge
in_rst  input  1  synchronous reset, active-high
in_alu_done  input  1  ALU result valid
in_alu_dst_rob_index  input  ROB_IDX_SIZE  ALU destination ROB index
in_alu_value  input  GPR_SIZE  ALU result
in_alu_set_nzcv  input  1  ALU result writes flags
in_alu_nzcv  input  4  ALU flags {N,Z,C,V}
out_alu_ready  output  1  ALU FIFO can accept this cycle
in_ls_done  input  1  load/store result valid
in_ls_dst_rob_index  input  ROB_IDX_SIZE  LS destination ROB index
in_ls_value  input  GPR_SIZE  LS result (load data; 0 for stores)
out_ls_ready  output  1  LS FIFO can accept this cycle
in_rob_ready  input  1  ROB accepts the current output
out_rob_done  output  1  output valid
out_rob_dst_rob_index  output  ROB_IDX_SIZE  granted ROB index
out_rob_value  output  GPR_SIZE  granted value
out_rob_set_nzcv  output  1  granted set-flags bit (always 0 for LS)
out_rob_nzcv  output  4  granted flags (0 for LS)
out_rob_src_ls  output  1  1 = granted entry came from LS, 0 = ALU

Behaviour:
- Reset (in_rst high at posedge): both FIFOs empty, pointers/counts 0, all out_rob_* 0, last_grant = LS so the ALU wins the first tie. Reset overrides any in-flight push/pop in the same cycle; FIFO contents are discarded.
- out_alu_ready = (alu_count < FIFO_DEPTH); same rule for out_ls_ready. Combinational from the registered count only; a pop in the same cycle does not raise ready.
- Push: in_X_done && out_X_ready at posedge writes the payload at the tail and increments the count. in_X_done while not ready is ignored, and the source must hold its result. Ready is never in the done path.
- Output register load enable: load_en = !out_rob_done || in_rob_ready.
- When load_en is high, the arbiter picks one source:
  - Both FIFOs non-empty: grant the source != last_grant.
  - One FIFO non-empty: grant that source.
  - Neither non-empty: no grant.
- On a grant: pop the head of the granted FIFO, load its payload into out_rob_*, set out_rob_done = 1, last_grant = granted source.
- No grant with load_en high: out_rob_done <= 0. Payload outputs hold their previous value and are don't-care while done = 0.
- Stall (out_rob_done && !in_rob_ready): all out_rob_* are held unchanged, no pop occurs, and pushes continue until the FIFOs are full.
- Latency: a result pushed at edge E0 into an empty FIFO with a free output is visible on out_rob_done after edge E1. Minimum latency is 1 cycle. There is no combinational bypass.
- Throughput: one result per cycle sustained while in_rob_ready = 1. Under contention, ALU and LS alternate strictly.
- Simultaneous push and pop on the same FIFO: both take effect and the count is unchanged. The popped entry is the old head.
- Pointers wrap modulo FIFO_DEPTH. Order within one source is FIFO, so there is no reordering per unit.
- LS entries always drive set_nzcv = 0 and nzcv = 0.

Test Plan:
- Single ALU: after reset, push ALU {idx=3, value=0x10, set_nzcv=1, nzcv=4'b0100} at E0 with in_rob_ready=1 -> out_rob_done=1 after E1 with idx 3, value 0x10, nzcv 4'b0100, src_ls=0; out_rob_done=0 after E2.
- Tie round-robin: push ALU idx=1 and LS idx=2 in the same cycle, then ALU idx=5 and LS idx=6 the next cycle -> output order after reset is idx 1, 2, 5, 6 (ALU first, then strict alternation).
- Backpressure: hold in_rob_ready=0 with an LS result on the output and push 3 ALU results back-to-back -> out_alu_ready drops to 0 after the 2nd ALU push; the 3rd is held by the source; out_rob_* stays frozen. Release ready -> all entries drain with no loss or duplication.
- Full FIFO with concurrent pop: ALU FIFO full, in_rob_ready=1, in_alu_done=1 -> no push that cycle (ready=0). One entry drains and the next cycle accepts the push; count never exceeds 2.
- Reset mid-operation: both FIFOs holding entries, out_rob_done=1, assert in_rst for one cycle -> next cycle out_rob_done=0, both ready=1, and the first subsequent tie grants the ALU.
- Pointer wrap: 10 sequential ALU pushes with idx 0..9 and in_rob_ready=1 -> the same idx sequence emerges in order with value intact.
